// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB request arbiter.
// State encoding, requester count and default address window.
package apb_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    localparam logic [31:0] DEF_ADDR_BASE  = 32'h1000_0000;
    localparam logic [31:0] DEF_ADDR_LIMIT = 32'h1000_3FFF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETUP_WAIT,
        ACCESS_WAIT,
        RESP
    } arb_state_e;

    // Both window bounds are inclusive.
    function automatic logic addr_in_range(
        input logic [31:0] a,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-master-side signals of the arbiter.
// master: the arbiter; slave: requesters plus APB master.
interface apb_req_arbiter_if;
    import apb_arb_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_write;
    logic [NUM_REQ-1:0][31:0] req_addr;
    logic [NUM_REQ-1:0][31:0] req_wdata;
    logic [NUM_REQ-1:0]       rsp_done;
    logic [NUM_REQ-1:0]       rsp_err;
    logic [31:0]              rsp_rdata;
    logic                     m_transfer;
    logic                     m_write;
    logic [31:0]              m_addr;
    logic [31:0]              m_wdata;
    logic                     m_ready;
    logic [31:0]              m_rdata;
    logic                     busy;
    logic [IDX_W-1:0]         gnt_id;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  m_ready, m_rdata,
        output rsp_done, rsp_err, rsp_rdata,
        output m_transfer, m_write, m_addr, m_wdata,
        output busy, gnt_id
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output m_ready, m_rdata,
        input  rsp_done, rsp_err, rsp_rdata,
        input  m_transfer, m_write, m_addr, m_wdata,
        input  busy, gnt_id
    );

endinterface

// File: rtl/apb_req_arbiter_rr.sv
// Four-way round-robin selector.
// Search starts one past the pointer and wraps modulo 4.
module rr_arbiter4
    import apb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // First requester at or after ptr+1, wrapping through ptr itself.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ptr_i + IDX_W'(k);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates four requesters onto one APB master port.
// Unmapped addresses are answered locally with an error.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = DEF_ADDR_BASE,
    parameter logic [31:0] ADDR_LIMIT = DEF_ADDR_LIMIT
) (
    input  logic               PCLK,
    input  logic               PRESET,
    apb_req_arbiter_if.master  bus
);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   gnt_id_q;
    logic               wr_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               m_transfer_q;
    logic               busy_q;
    logic [NUM_REQ-1:0] rsp_done_q;
    logic [NUM_REQ-1:0] rsp_err_q;
    logic [31:0]        rsp_rdata_q;

    logic [NUM_REQ-1:0] win_gnt;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic               wr_d;
    logic [31:0]        addr_d;
    logic [31:0]        wdata_d;
    logic               mapped_d;
    logic [NUM_REQ-1:0] cur_onehot;

    rr_arbiter4 u_rr (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    // Winner's request fields, captured on the grant edge.
    always_comb begin
        wr_d     = bus.req_write[win_idx];
        addr_d   = bus.req_addr[win_idx];
        wdata_d  = bus.req_wdata[win_idx];
        mapped_d = addr_in_range(addr_d, ADDR_BASE, ADDR_LIMIT);
    end

    assign cur_onehot = NUM_REQ'(1) << gnt_id_q;

    // Grant, APB sequencing and registered responses in one FSM.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            ptr_q        <= IDX_W'(NUM_REQ - 1);
            gnt_id_q     <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            m_transfer_q <= 1'b0;
            busy_q       <= 1'b0;
            rsp_done_q   <= '0;
            rsp_err_q    <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_any) begin
                        ptr_q    <= win_idx;
                        gnt_id_q <= win_idx;
                        wr_q     <= wr_d;
                        addr_q   <= addr_d;
                        wdata_q  <= wdata_d;
                        busy_q   <= 1'b1;
                        if (mapped_d) begin
                            state_q      <= ISSUE;
                            m_transfer_q <= 1'b1;
                        end else begin
                            state_q     <= RESP;
                            rsp_done_q  <= win_gnt;
                            rsp_err_q   <= win_gnt;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    m_transfer_q <= 1'b0;
                    state_q      <= SETUP_WAIT;
                end
                SETUP_WAIT: begin
                    state_q <= ACCESS_WAIT;
                end
                ACCESS_WAIT: begin
                    if (bus.m_ready) begin
                        state_q     <= RESP;
                        rsp_done_q  <= cur_onehot;
                        rsp_err_q   <= '0;
                        rsp_rdata_q <= wr_q ? 32'h0 : bus.m_rdata;
                    end
                end
                RESP: begin
                    rsp_done_q <= '0;
                    rsp_err_q  <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_done   = rsp_done_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.m_transfer = m_transfer_q;
    assign bus.m_write    = wr_q;
    assign bus.m_addr     = addr_q;
    assign bus.m_wdata    = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.gnt_id     = gnt_id_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: vector table, corner sequences and
// random traffic against a transaction-timeline reference model.
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    localparam logic [31:0] LO = 32'h1000_0000;
    localparam logic [31:0] HI = 32'h1000_3FFF;

    logic PCLK = 1'b0;
    logic PRESET;

    always #5 PCLK = ~PCLK;

    apb_req_arbiter_if bus();

    apb_req_arbiter #(
        .ADDR_BASE  (LO),
        .ADDR_LIMIT (HI)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0]  valid;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          w;
        logic [3:0]  e_done;
        logic [3:0]  e_err;
        int          e_lat;
        logic [31:0] e_rdata;
        int          e_mtx;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: one transaction described by its grant cycle
    // and the cycle its response is due.
    int          cyc = 0;
    bit          act;
    int          g, done_c, w, id, last, gnt_exp;
    bit          err, wr;
    logic [31:0] addr, wdata, rd_val, exp_rdata;
    int          grant_cnt = 0;
    int          dut_done = 0;
    int          done_log[$];
    logic [3:0]  dropped = '0;

    int          raise_pct = 0;
    bit          wr_only = 0;
    int          fixed_w = -1;
    bit          use_fixed_rd = 0;
    logic [31:0] fixed_rd = '0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, a, e, cyc);
        end
    endtask

    task automatic model_reset();
        act       = 0;
        last      = 3;
        gnt_exp   = 0;
        exp_rdata = '0;
    endtask

    function automatic logic [31:0] mapped_addr();
        return LO + (32'($urandom_range(0, 4095)) << 2);
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return LO;
            1: return HI;
            2: return HI + 32'd1;
            3: return LO - 32'd1;
            4: return $urandom;
            5: return 32'h0;
            default: return mapped_addr();
        endcase
    endfunction

    task automatic raise_reqs();
        for (int i = 0; i < 4; i++) begin
            if (!bus.req_valid[i] && !dropped[i] && raise_pct > 0 &&
                int'($urandom_range(1, 100)) <= raise_pct) begin
                bus.req_valid[i] = 1'b1;
                bus.req_write[i] = wr_only ? 1'b1 : 1'($urandom_range(0, 1));
                bus.req_addr[i]  = wr_only ? mapped_addr() : pick_addr();
                bus.req_wdata[i] = $urandom;
            end
        end
        dropped = '0;
    endtask

    task automatic model_grant();
        int j;
        bit hit;
        if (PRESET || (act && cyc <= done_c) || bus.req_valid == 4'b0000)
            return;
        j = 0;
        hit = 0;
        for (int k = 1; k <= 4; k++) begin
            if (!hit && bus.req_valid[(last + k) % 4]) begin
                hit = 1;
                j = (last + k) % 4;
            end
        end
        act     = 1;
        g       = cyc;
        id      = j;
        last    = j;
        gnt_exp = j;
        wr      = bus.req_write[j];
        addr    = bus.req_addr[j];
        wdata   = bus.req_wdata[j];
        err     = !(addr >= LO && addr <= HI);
        w       = (fixed_w >= 0) ? fixed_w : int'($urandom_range(0, 4));
        rd_val  = use_fixed_rd ? fixed_rd : $urandom;
        done_c  = err ? g + 1 : g + 4 + w;
        grant_cnt++;
    endtask

    // APB slave: ready is also raised in ISSUE/SETUP, where it must be
    // ignored; real data appears only on the completing access cycle.
    task automatic slave_drive();
        bus.m_ready = 1'($urandom_range(0, 1));
        bus.m_rdata = $urandom;
        if (act && !err) begin
            if (cyc == g + 1 || cyc == g + 2) begin
                bus.m_ready = 1'b1;
            end else if (cyc >= g + 3 && cyc < g + 3 + w) begin
                bus.m_ready = 1'b0;
            end else if (cyc == g + 3 + w) begin
                bus.m_ready = 1'b1;
                bus.m_rdata = rd_val;
            end
        end
    endtask

    task automatic check_all();
        bit         busy_e, mt_e;
        logic [3:0] done_e, err_e;
        busy_e = act && cyc > g && cyc <= done_c;
        mt_e   = act && !err && cyc == g + 1;
        done_e = (act && cyc == done_c) ? (4'b0001 << id) : 4'b0000;
        err_e  = err ? done_e : 4'b0000;
        if (act && cyc == done_c)
            exp_rdata = (err || wr) ? 32'h0 : rd_val;
        chk("busy", 32'(bus.busy), 32'(busy_e));
        chk("m_transfer", 32'(bus.m_transfer), 32'(mt_e));
        chk("rsp_done", 32'(bus.rsp_done), 32'(done_e));
        chk("rsp_err", 32'(bus.rsp_err), 32'(err_e));
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
        chk("gnt_id", 32'(bus.gnt_id), 32'(gnt_exp));
        if (act && !err && cyc > g && cyc < done_c) begin
            chk("m_addr", bus.m_addr, addr);
            chk("m_write", 32'(bus.m_write), 32'(wr));
            chk("m_wdata", bus.m_wdata, wdata);
        end
    endtask

    task automatic cycle();
        bit rst_now;
        raise_reqs();
        model_grant();
        slave_drive();
        rst_now = PRESET;
        @(posedge PCLK);
        #1;
        cyc++;
        if (rst_now)
            model_reset();
        check_all();
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_done[i]) begin
                done_log.push_back(i);
                dut_done++;
            end
        end
        if (act && cyc == done_c) begin
            bus.req_valid[id] = 1'b0;
            dropped[id] = 1'b1;
        end
    endtask

    vec_t tbl[7];
    int   exp_ord[5];

    initial begin
        tbl[0] = '{4'b0001, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 0,
                   4'b0001, 4'b0000, 4, 32'hDEAD_BEEF, 1};
        tbl[1] = '{4'b0100, 1'b0, 32'h2000_0000, 32'h0, 32'h5555_5555, 0,
                   4'b0100, 4'b0100, 1, 32'h0, 0};
        tbl[2] = '{4'b0010, 1'b0, 32'h1000_3FFF, 32'h0, 32'h1234_5678, 0,
                   4'b0010, 4'b0000, 4, 32'h1234_5678, 1};
        tbl[3] = '{4'b1000, 1'b0, 32'h1000_4000, 32'h0, 32'h9999_9999, 0,
                   4'b1000, 4'b1000, 1, 32'h0, 0};
        tbl[4] = '{4'b0001, 1'b1, 32'h1000_0000, 32'hA5A5_A5A5, 32'h7777_7777, 2,
                   4'b0001, 4'b0000, 6, 32'h0, 1};
        tbl[5] = '{4'b0010, 1'b0, 32'h0FFF_FFFF, 32'h0, 32'h3333_3333, 0,
                   4'b0010, 4'b0010, 1, 32'h0, 0};
        tbl[6] = '{4'b1000, 1'b0, 32'h1000_0100, 32'h0, 32'hCAFE_F00D, 5,
                   4'b1000, 4'b0000, 9, 32'hCAFE_F00D, 1};
        exp_ord = '{0, 1, 2, 3, 0};

        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.m_ready   = 1'b0;
        bus.m_rdata   = '0;
        PRESET        = 1'b1;
        model_reset();

        cycle();
        cycle();
        chk("rst m_addr", bus.m_addr, 32'h0);
        chk("rst m_wdata", bus.m_wdata, 32'h0);
        chk("rst m_write", 32'(bus.m_write), 32'h0);
        chk("rst busy", 32'(bus.busy), 32'h0);
        chk("rst gnt_id", 32'(bus.gnt_id), 32'h0);
        PRESET = 1'b0;
        cycle();
        cycle();

        // Single transactions with hand-computed results.
        use_fixed_rd = 1;
        for (int v = 0; v < 7; v++) begin
            int idx, t0, lat, mtx;
            bit seen;
            idx = 0;
            for (int i = 0; i < 4; i++)
                if (tbl[v].valid[i]) idx = i;
            fixed_w  = tbl[v].w;
            fixed_rd = tbl[v].rd;
            bus.req_valid[idx] = 1'b1;
            bus.req_write[idx] = tbl[v].wr;
            bus.req_addr[idx]  = tbl[v].addr;
            bus.req_wdata[idx] = tbl[v].wdata;
            t0 = cyc;
            seen = 0;
            mtx = 0;
            lat = 0;
            for (int k = 0; k < 14; k++) begin
                cycle();
                if (bus.m_transfer) mtx++;
                if (!seen && bus.rsp_done != 4'b0000) begin
                    seen = 1;
                    lat = cyc - t0;
                    chk($sformatf("v%0d done", v), 32'(bus.rsp_done),
                        32'(tbl[v].e_done));
                    chk($sformatf("v%0d err", v), 32'(bus.rsp_err),
                        32'(tbl[v].e_err));
                    chk($sformatf("v%0d rdata", v), bus.rsp_rdata,
                        tbl[v].e_rdata);
                    chk($sformatf("v%0d latency", v), lat, tbl[v].e_lat);
                end
            end
            if (!seen) begin
                n_chk++;
                n_fail++;
                $display("FAIL v%0d timeout: got no rsp_done expected one", v);
            end
            chk($sformatf("v%0d m_transfer cycles", v), mtx, tbl[v].e_mtx);
        end

        // All four requesters writing back-to-back.
        PRESET = 1'b1;
        bus.req_valid = '0;
        cycle();
        PRESET = 1'b0;
        cycle();
        done_log.delete();
        raise_pct = 100;
        wr_only = 1;
        use_fixed_rd = 0;
        fixed_w = -1;
        for (int k = 0; k < 80 && done_log.size() < 5; k++)
            cycle();
        raise_pct = 0;
        repeat (60) cycle();
        for (int i = 0; i < 5; i++) begin
            if (i < done_log.size()) begin
                chk($sformatf("rr order %0d", i), done_log[i], exp_ord[i]);
            end else begin
                n_chk++;
                n_fail++;
                $display("FAIL rr order %0d: got none expected %0d",
                         i, exp_ord[i]);
            end
        end

        // Reset while the slave is stalling in the access phase.
        wr_only = 0;
        fixed_w = 5;
        use_fixed_rd = 1;
        fixed_rd = 32'h0BAD_F00D;
        bus.req_valid[2] = 1'b1;
        bus.req_write[2] = 1'b0;
        bus.req_addr[2]  = LO + 32'h40;
        repeat (4) cycle();
        chk("pre-reset busy", 32'(bus.busy), 32'h1);
        PRESET = 1'b1;
        bus.req_valid = '0;
        cycle();
        PRESET = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'h0);
        chk("abort rsp_done", 32'(bus.rsp_done), 32'h0);
        done_log.delete();
        fixed_w = 0;
        for (int i = 0; i < 2; i++) begin
            bus.req_valid[i] = 1'b1;
            bus.req_write[i] = 1'b1;
            bus.req_addr[i]  = LO + 32'(i * 8);
            bus.req_wdata[i] = $urandom;
        end
        repeat (20) cycle();
        if (done_log.size() >= 2) begin
            chk("post-reset first", done_log[0], 0);
            chk("post-reset second", done_log[1], 1);
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL post-reset: got %0d completions expected 2",
                     done_log.size());
        end

        // Random traffic.
        PRESET = 1'b1;
        bus.req_valid = '0;
        cycle();
        PRESET = 1'b0;
        dut_done = 0;
        grant_cnt = 0;
        raise_pct = 30;
        fixed_w = -1;
        use_fixed_rd = 0;
        repeat (2000) cycle();
        raise_pct = 0;
        repeat (60) cycle();
        chk("txn count", dut_done, grant_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter: ADDR_BASE, 32'h1000_0000, lowest mapped APB address.
REQ-002 Parameter: ADDR_LIMIT, 32'h1000_3FFF, highest mapped APB address (inclusive).
REQ-003 Clocking is fixed: one clock, PCLK; reset is PRESET, synchronous and active-high.
REQ-004 Ports SHALL be:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous active-high reset.
- req_valid  in  4  per-requester request, level-held until rsp_done.
- req_write  in  4  per-requester write flag.
- req_addr  in  4x32  per-requester address.
- req_wdata  in  4x32  per-requester write data.
- rsp_done  out  4  one-hot, 1-cycle completion pulse.
- rsp_err  out  4  error flag, valid with rsp_done.
- rsp_rdata  out  32  read data, valid with rsp_done.
- m_transfer  out  1  to APB master transfer.
- m_write  out  1  to APB master write.
- m_addr  out  32  to APB master addr.
- m_wdata  out  32  to APB master wdata.
- m_ready  in  1  from APB master ready.
- m_rdata  in  32  from APB master rdata.
- busy  out  1  high in any state except IDLE.
- gnt_id  out  2  index of the current or last granted requester.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, SETUP_WAIT, ACCESS_WAIT and RESP.
REQ-006 In IDLE with any req_valid high, the block SHALL grant round-robin, searching from last-granted+1 modulo 4, and register write, addr and wdata of the winner.
REQ-007 Grant transition: IDLE->ISSUE if ADDR_BASE <= addr <= ADDR_LIMIT, else IDLE->RESP with err=1 and rdata=0, with no APB transfer.
REQ-008 ISSUE SHALL assert m_transfer for exactly one cycle, then go to SETUP_WAIT; m_transfer SHALL be 0 in all other states.
REQ-009 m_write, m_addr and m_wdata SHALL be driven from the grant registers and held stable from ISSUE through ACCESS_WAIT.
REQ-010 SETUP_WAIT SHALL last one cycle and ignore m_ready (the master is in SETUP), then go to ACCESS_WAIT.
REQ-011 In ACCESS_WAIT, m_ready=1 SHALL capture m_rdata (0 for writes) and move to RESP; m_ready=0 SHALL hold the state, with no timeout.
REQ-012 RESP SHALL assert rsp_done[gnt_id] for one cycle, with rsp_err and rsp_rdata valid, then return to IDLE.
REQ-013 rsp_done, rsp_err and rsp_rdata SHALL be registered; rsp_rdata SHALL hold its value until the next RESP.
REQ-014 Minimum latency from grant (IDLE cycle) to rsp_done: 4 cycles for a mapped address, 1 cycle for an unmapped address.
REQ-015 A requester SHALL drop req_valid on the edge where it samples rsp_done high; the arbiter SHALL NOT filter stale requests.
REQ-016 Requests arriving while busy SHALL wait, and SHALL be arbitrated in the next IDLE cycle.
REQ-017 The round-robin pointer SHALL update only on grant, including error grants.
REQ-018 Address bounds SHALL be inclusive at both ends: ADDR_LIMIT is mapped, ADDR_LIMIT+1 is an error.

Reset
REQ-019 PRESET SHALL force IDLE, last-granted=3 (so requester 0 wins first), gnt_id=0, all rsp_* and m_* outputs to 0, and busy=0.
REQ-020 PRESET mid-transaction SHALL abort without a rsp_done pulse; the same PRESET resets the APB master.

Structure
REQ-021 The state enum, NUM_REQ=4 and the default address bounds SHALL live in a shared package, apb_arb_pkg.
REQ-022 The round-robin selector SHALL be one sub-module, rr_arbiter4 (inputs: request vector and pointer; outputs: one-hot grant and index).

Verification
REQ-023 Single read: req_valid=0001, addr 32'h1000_0004, slave ready immediately, rdata 32'hDEAD_BEEF -> m_transfer 1 cycle; rsp_done=0001, rsp_rdata=32'hDEAD_BEEF, rsp_err=0 four cycles after grant.
REQ-024 All four requesting writes continuously -> grant order 0,1,2,3,0; exactly one rsp_done per transaction.
REQ-025 Unmapped addr 32'h2000_0000 on requester 2 -> no m_transfer; rsp_done=0100 and rsp_err=0100 the next cycle, rsp_rdata=0.
REQ-026 Boundaries: addr 32'h1000_3FFF -> APB transfer, err=0; addr 32'h1000_4000 -> err=1.
REQ-027 Slave with 5 wait states -> state held in ACCESS_WAIT with m_addr stable throughout; done one cycle after m_ready.
REQ-028 PRESET asserted in ACCESS_WAIT -> next cycle IDLE, busy=0, no rsp_done; the next grant goes to requester 0.
